// File: rtl/edp_fm_parity_chk.sv
// Fast-memory (AC block) parity tracker/checker fed by the six EDP slice parities.
// Optional parity-inject diagnostic is compiled in with `define EDP_FM_PAR_INJECT_EN.
module edp_fm_parity_chk #(
  parameter int BLOCKS = 8,
  parameter int CNT_W  = 8
) (
  input  logic                          clk_edp_h,
  input  logic                          edp_reset_l,
  input  logic [$clog2(BLOCKS)-1:0]     apr_fm_block_h,
  input  logic [3:0]                    apr_fm_adr_h,
  input  logic                          con_fm_write_00to17_l,
  input  logic                          con_fm_write_18to35_l,
  input  logic                          apr_fm_read_h,
  input  logic [5:0]                    edp_fm_parity_h,
  input  logic                          apr_fm_par_chk_en_h,
  input  logic                          apr_fm_par_err_clr_h,
  input  logic                          diag_fm_par_inject_h,
  output logic                          fm_par_err_h,
  output logic [1:0]                    fm_par_err_half_h,
  output logic [$clog2(BLOCKS)+3:0]     fm_par_err_adr_h,
  output logic                          fm_par_err_overrun_h,
  output logic [CNT_W-1:0]              fm_par_err_cnt_h
);

  localparam int IDX_W   = $clog2(BLOCKS) + 4;
  localparam int ENTRIES = 2 ** IDX_W;

  function automatic logic par3(input logic [2:0] p);
    return ^p;
  endfunction

  logic [IDX_W-1:0]   idx_s;
  logic               wr_l_s, wr_r_s, inj_s;
  logic               new_par_l_s, new_par_r_s;
  logic               chk_par_l_s, chk_par_r_s;
  logic               mis_l_s, mis_r_s, mis_any_s;

  logic [ENTRIES-1:0] vld_l_q, par_l_q, vld_r_q, par_r_q;

  logic               rd_pend_q, rd_pend_d;
  logic               rd_en_q, rd_en_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               rd_vld_l_q, rd_vld_l_d, rd_par_l_q, rd_par_l_d;
  logic               rd_vld_r_q, rd_vld_r_d, rd_par_r_q, rd_par_r_d;

  logic               err_q, err_d;
  logic [1:0]         half_q, half_d;
  logic [IDX_W-1:0]   adr_q, adr_d;
  logic               ovr_q, ovr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign idx_s  = {apr_fm_block_h, apr_fm_adr_h};
  assign wr_l_s = ~con_fm_write_00to17_l;
  assign wr_r_s = ~con_fm_write_18to35_l;

`ifdef EDP_FM_PAR_INJECT_EN
  assign inj_s = diag_fm_par_inject_h;
`else
  assign inj_s = diag_fm_par_inject_h & 1'b0;
`endif

  assign new_par_l_s = par3(edp_fm_parity_h[2:0]) ^ inj_s;
  assign new_par_r_s = par3(edp_fm_parity_h[5:3]) ^ inj_s;
  assign chk_par_l_s = par3(edp_fm_parity_h[2:0]);
  assign chk_par_r_s = par3(edp_fm_parity_h[5:3]);

  // Parity/valid storage, one flop pair per half per entry
  always_ff @(posedge clk_edp_h or negedge edp_reset_l) begin
    if (!edp_reset_l) begin
      vld_l_q <= '0;
      par_l_q <= '0;
      vld_r_q <= '0;
      par_r_q <= '0;
    end else begin
      if (wr_l_s) begin
        vld_l_q[idx_s] <= 1'b1;
        par_l_q[idx_s] <= new_par_l_s;
      end
      if (wr_r_s) begin
        vld_r_q[idx_s] <= 1'b1;
        par_r_q[idx_s] <= new_par_r_s;
      end
    end
  end

  // Read capture; a same-cycle write to the read index takes precedence
  always_comb begin
    rd_pend_d  = apr_fm_read_h;
    rd_en_d    = rd_en_q;
    rd_idx_d   = rd_idx_q;
    rd_vld_l_d = rd_vld_l_q;
    rd_par_l_d = rd_par_l_q;
    rd_vld_r_d = rd_vld_r_q;
    rd_par_r_d = rd_par_r_q;
    if (apr_fm_read_h) begin
      rd_en_d  = apr_fm_par_chk_en_h;
      rd_idx_d = idx_s;
      if (wr_l_s) begin
        rd_vld_l_d = 1'b1;
        rd_par_l_d = new_par_l_s;
      end else begin
        rd_vld_l_d = vld_l_q[idx_s];
        rd_par_l_d = par_l_q[idx_s];
      end
      if (wr_r_s) begin
        rd_vld_r_d = 1'b1;
        rd_par_r_d = new_par_r_s;
      end else begin
        rd_vld_r_d = vld_r_q[idx_s];
        rd_par_r_d = par_r_q[idx_s];
      end
    end else begin
      rd_en_d = rd_en_q;
    end
  end

  assign mis_l_s   = rd_pend_q & rd_en_q & rd_vld_l_q & (rd_par_l_q != chk_par_l_s);
  assign mis_r_s   = rd_pend_q & rd_en_q & rd_vld_r_q & (rd_par_r_q != chk_par_r_s);
  assign mis_any_s = mis_l_s | mis_r_s;

  // Error latch and counter; clear beats a coincident mismatch
  always_comb begin
    err_d  = err_q;
    half_d = half_q;
    adr_d  = adr_q;
    ovr_d  = ovr_q;
    cnt_d  = cnt_q;
    if (apr_fm_par_err_clr_h) begin
      err_d  = 1'b0;
      half_d = 2'b00;
      adr_d  = '0;
      ovr_d  = 1'b0;
      cnt_d  = '0;
    end else if (mis_any_s) begin
      if (err_q) begin
        ovr_d = 1'b1;
      end else begin
        err_d  = 1'b1;
        half_d = {mis_l_s, mis_r_s};
        adr_d  = rd_idx_q;
      end
      if (&cnt_q) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      err_d = err_q;
    end
  end

  // Pipeline and error state registers
  always_ff @(posedge clk_edp_h or negedge edp_reset_l) begin
    if (!edp_reset_l) begin
      rd_pend_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      rd_vld_l_q <= 1'b0;
      rd_par_l_q <= 1'b0;
      rd_vld_r_q <= 1'b0;
      rd_par_r_q <= 1'b0;
      err_q      <= 1'b0;
      half_q     <= 2'b00;
      adr_q      <= '0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_en_q    <= rd_en_d;
      rd_idx_q   <= rd_idx_d;
      rd_vld_l_q <= rd_vld_l_d;
      rd_par_l_q <= rd_par_l_d;
      rd_vld_r_q <= rd_vld_r_d;
      rd_par_r_q <= rd_par_r_d;
      err_q      <= err_d;
      half_q     <= half_d;
      adr_q      <= adr_d;
      ovr_q      <= ovr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fm_par_err_h         = err_q;
  assign fm_par_err_half_h    = half_q;
  assign fm_par_err_adr_h     = adr_q;
  assign fm_par_err_overrun_h = ovr_q;
  assign fm_par_err_cnt_h     = cnt_q;

endmodule

// File: doc/edp_fm_parity_chk.md
# edp_fm_parity_chk

Fast-memory (AC block) parity tracker and checker. It sits directly downstream of the six EDP 6-bit slices and consumes their per-slice FM parity outputs; slice 18–23 drives bit 3. On each FM write it records the parity of the written half-word. On each FM read it compares the recomputed parity against the stored value and latches a sticky error with its address for the APR. Storage covers all 8 blocks × 16 ACs × 2 half-words.

## Interface
Parameters:
- BLOCKS, 8, number of AC blocks (address bits = log2(BLOCKS) + 4)
- CNT_W, 8, width of the saturating error counter

Ports:
- clk_edp_h  in  1  EDP clock; all state updates on the rising edge
- edp_reset_l  in  1  asynchronous, active-low reset
- apr_fm_block_h  in  3  current AC block
- apr_fm_adr_h  in  4  AC address within the block
- con_fm_write_00to17_l  in  1  low = write left half this cycle
- con_fm_write_18to35_l  in  1  low = write right half this cycle
- apr_fm_read_h  in  1  high = FM read issued this cycle
- edp_fm_parity_h  in  6  slice parities; bit n covers bits 6n..6n+5; high = odd count of ones
- apr_fm_par_chk_en_h  in  1  enables checking
- apr_fm_par_err_clr_h  in  1  clears the error latch, overrun flag and counter
- diag_fm_par_inject_h  in  1  inverts stored parity on writes (only with EDP_FM_PAR_INJECT_EN)
- fm_par_err_h  out  1  sticky parity error
- fm_par_err_half_h  out  2  failing half(s) of the first error; [1] = left, [0] = right
- fm_par_err_adr_h  out  7  {block, adr} of the first error
- fm_par_err_overrun_h  out  1  a further error occurred while the latch was set
- fm_par_err_cnt_h  out  CNT_W  saturating count of detected errors

## Operation
Storage:
- 128 entries × {valid, par} per half, all held in flops.
- Left parity = XOR of edp_fm_parity_h[2:0]. Right parity = XOR of [5:3].

Write:
- An active-low write strobe stores the parity of that half and sets its valid bit at index {block, adr}.
- The two halves are written independently.

Read:
- apr_fm_read_h high registers the index, the stored {valid, par} for both halves, and a check-pending flag.
- If the same cycle also writes the same index, the new {1, par} is bypassed into the compare register (write wins).

Check:
- The cycle after the read, edp_fm_parity_h reflects FM output data. For each half: mismatch = valid & (stored par != recomputed par).
- Checking happens only if apr_fm_par_chk_en_h was high in the read cycle.
- Entries that have never been written (valid = 0) are not checked.

Error latch:
- On any mismatch with fm_par_err_h low: set fm_par_err_h, capture the half mask and the index.
- On a mismatch with fm_par_err_h already high: set fm_par_err_overrun_h; the captured address and half mask are unchanged.
- Each mismatching check cycle increments the counter by 1, not per half. The counter saturates at all ones.

Clear:
- apr_fm_par_err_clr_h clears the latch, half mask, address, overrun flag and counter.
- Clear has priority over a same-cycle mismatch; that mismatch is lost.
- Stored parity is unaffected by clear.

## Timing
- Reset (async): all outputs 0, all valid bits 0, check-pending 0.
- Write-to-stored latency: 1 edge. A read on the next cycle sees the new value.
- Read issued in cycle k; parity sampled and compared at edge k+1; fm_par_err_h visible after edge k+1.
- Back-to-back reads every cycle are fully pipelined.
- Reset asserted mid-check discards the pending check.
- Reset deasserts synchronously to clk_edp_h through the upstream synchronizer. This block does not resynchronize it.

## Configuration
EDP_FM_PAR_INJECT_EN:
- Defined: when diag_fm_par_inject_h is high during a write, the stored par is inverted for every half being written. This forces a mismatch on the next read of that location.
- Undefined: diag_fm_par_inject_h is present but ignored, and stored parity is always the true value.

## Test plan
- Reset, write right half of block 2 AC 5 with slice parities 6'b001000; read it with slice parities 6'b001000 -> no error, cnt = 0.
- Same write, then read with slice parities 6'b000000 -> after edge k+1: err = 1, half = 2'b01, adr = 7'h25, cnt = 1.
- Second mismatching read at block 7 AC 15 while err = 1 -> overrun = 1, adr stays 7'h25, cnt = 2. Pulse clr -> all zero.
- Read never-written block 0 AC 0 with slice parities 6'b111111 -> no error. Same-cycle write+read of one index with parities 6'b000001 and the following cycle's parities 6'b000001 -> no error (bypass).
- With EDP_FM_PAR_INJECT_EN: write both halves with inject = 1, then read with identical parities -> err = 1, half = 2'b11. Without the macro, the same sequence gives no error.
- Force 300 mismatches with CNT_W = 8 -> cnt holds 8'hFF. Assert reset mid-pending-check -> no error is flagged after release.
